// File: rtl/round_robin_grant_scheduler.sv
// Round-robin arbiter granting one of INPUT_COUNT requesters via a valid/ready handshake.
// Each grant is held until it is accepted, followed by a one-cycle bubble.
//
// state | meaning
// IDLE  | no grant presented; scanning requests from the priority pointer
// GRANT | grant presented and held until grant_ready
module round_robin_grant_scheduler #(
  parameter int INPUT_COUNT = 4,
  parameter int INDEX_WIDTH = 2
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic [INPUT_COUNT-1:0] requests,
  output logic                   grant_valid,
  input  logic                   grant_ready,
  output logic [INDEX_WIDTH-1:0] grant_index,
  output logic [INPUT_COUNT-1:0] grant_one_hot
);

  localparam int SEL_W = (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                 state;
  logic [INDEX_WIDTH-1:0] ptr;
  logic                   pick_found;
  logic [INDEX_WIDTH-1:0] pick_index;
  int                     cand;

  // Scan upward from the pointer; the wrap at INPUT_COUNT is explicit so
  // non-power-of-two counts never yield an out-of-range index.
  always_comb begin
    pick_found = 1'b0;
    pick_index = '0;
    cand       = 0;
    for (int k = 0; k < INPUT_COUNT; k++) begin
      cand = int'(ptr) + k;
      if (cand >= INPUT_COUNT) cand = cand - INPUT_COUNT;
      if (!pick_found && requests[SEL_W'(cand)]) begin
        pick_found = 1'b1;
        pick_index = INDEX_WIDTH'(cand);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state         <= IDLE;
      ptr           <= '0;
      grant_valid   <= 1'b0;
      grant_index   <= '0;
      grant_one_hot <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_valid   <= 1'b1;
            grant_index   <= pick_index;
            grant_one_hot <= INPUT_COUNT'(1) << pick_index;
            state         <= GRANT;
          end
        end
        GRANT: begin
          if (grant_ready) begin
            ptr           <= (grant_index == INDEX_WIDTH'(INPUT_COUNT - 1)) ? '0
                                                                            : grant_index + 1'b1;
            grant_valid   <= 1'b0;
            grant_index   <= '0;
            grant_one_hot <= '0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
